// File: rtl/processador_snoop_pkg.sv
// Shared codes for the snooping cache controller: bus messages, line states, FSM states, snoop rule.
// Exclusivo (MESI) exists only when MESI_EXCLUSIVE_EN is defined; otherwise the protocol is MSI.
package processador_snoop_pkg;

  localparam logic [1:0] MSG_INVALIDAR    = 2'b00;
  localparam logic [1:0] MSG_READ_MISS    = 2'b01;
  localparam logic [1:0] MSG_WRITE_MISS   = 2'b10;
  localparam logic [1:0] MSG_SEM_MENSAGEM = 2'b11;

  localparam logic [1:0] EST_INVALIDO      = 2'b00;
  localparam logic [1:0] EST_MODIFICADO    = 2'b01;
  localparam logic [1:0] EST_COMPARTILHADO = 2'b10;
`ifdef MESI_EXCLUSIVE_EN
  localparam logic [1:0] EST_EXCLUSIVO     = 2'b11;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOOKUP = 2'b01,
    S_WRBACK = 2'b10,
    S_FILL   = 2'b11
  } fsm_t;

  typedef struct packed {
    logic [1:0] proximo;
    logic       wb;
  } snoop_t;

  // Reaction of a line that matched another node's bus message.
  function automatic snoop_t snoop_next(input logic [1:0] estado, input logic [1:0] msg);
    snoop_t r;
    r.proximo = estado;
    r.wb      = 1'b0;
    case (estado)
      EST_MODIFICADO: begin
        if (msg == MSG_READ_MISS) begin
          r.proximo = EST_COMPARTILHADO;
          r.wb      = 1'b1;
        end else if (msg == MSG_WRITE_MISS) begin
          r.proximo = EST_INVALIDO;
          r.wb      = 1'b1;
        end
      end
      EST_COMPARTILHADO: begin
        if (msg == MSG_WRITE_MISS || msg == MSG_INVALIDAR) r.proximo = EST_INVALIDO;
      end
`ifdef MESI_EXCLUSIVE_EN
      EST_EXCLUSIVO: begin
        if (msg == MSG_READ_MISS) r.proximo = EST_COMPARTILHADO;
        else if (msg == MSG_WRITE_MISS || msg == MSG_INVALIDAR) r.proximo = EST_INVALIDO;
      end
`endif
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/processador_snoop_param_cache_linhas.sv
// Direct-mapped line storage (state/tag/data) with one async read port and one write port.
// Reset clears every line to invalido with zero tag and data.
module cache_linhas
  import processador_snoop_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 3,
  parameter int LINES  = 4,
  parameter int IDX_W  = $clog2(LINES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [1:0]        rd_estado,
  output logic [ADDR_W-1:0] rd_tag,
  output logic [DATA_W-1:0] rd_dado,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [1:0]        wr_estado,
  input  logic [ADDR_W-1:0] wr_tag,
  input  logic [DATA_W-1:0] wr_dado
);

  logic [1:0]        estado_q [LINES];
  logic [ADDR_W-1:0] tag_q    [LINES];
  logic [DATA_W-1:0] dado_q   [LINES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        estado_q[i] <= EST_INVALIDO;
        tag_q[i]    <= '0;
        dado_q[i]   <= '0;
      end
    end else if (we) begin
      estado_q[wr_idx] <= wr_estado;
      tag_q[wr_idx]    <= wr_tag;
      dado_q[wr_idx]   <= wr_dado;
    end
  end

  assign rd_estado = estado_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_dado   = dado_q[rd_idx];

endmodule

// File: rtl/processador_snoop_param.sv
// Snooping cache node: owner instrs hit/miss with write-back and fill, other nodes' instrs are snooped.
// Build option MESI_EXCLUSIVE_EN adds the compartilhado_bus input and the exclusivo line state.
//   state    | meaning
//   S_IDLE   | ready for an instr
//   S_LOOKUP | line read, hit/miss resolved, message or snoop applied
//   S_WRBACK | modificado victim written back
//   S_FILL   | memory read pending until mem_ack
module processador_snoop_param
  import processador_snoop_pkg::*;
#(
  parameter int PROC_ID_W = 2,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 3,
  parameter int LINES     = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [PROC_ID_W-1:0]                  id_processador,
  input  logic                                  instr_valid,
  input  logic [PROC_ID_W+1+ADDR_W+DATA_W-1:0]  instr,
  output logic                                  instr_ready,
  input  logic [1:0]                            entradaMaquina,
  output logic [1:0]                            saidaMaquina,
  output logic                                  WB,
  output logic [ADDR_W-1:0]                     enderecoWB,
  output logic [DATA_W-1:0]                     dadoWB,
  output logic                                  read,
  output logic [ADDR_W-1:0]                     enderecoMem,
  input  logic [DATA_W-1:0]                     dadoMem,
  input  logic                                  mem_ack,
`ifdef MESI_EXCLUSIVE_EN
  input  logic                                  compartilhado_bus,
`endif
  output logic [DATA_W-1:0]                     out,
  output logic                                  out_valid
);

  localparam int IDX_W = $clog2(LINES);

  fsm_t              state_q, state_d;
  logic              pronto_q;
  logic              dono_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        msg_q;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic [PROC_ID_W-1:0] instr_owner;
  logic                 instr_wr;
  logic [ADDR_W-1:0]    instr_addr;
  logic [DATA_W-1:0]    instr_wdata;

  logic [IDX_W-1:0]  idx;
  logic [1:0]        rd_estado;
  logic [ADDR_W-1:0] rd_tag;
  logic [DATA_W-1:0] rd_dado;
  logic              we;
  logic [1:0]        wr_estado;
  logic [ADDR_W-1:0] wr_tag;
  logic [DATA_W-1:0] wr_dado;

  logic              aceita;
  logic              hit;
  snoop_t            snoop;
  logic [1:0]        estado_fill;
  logic [1:0]        saida_d;
  logic              wb_d;
  logic              read_d;

  assign {instr_owner, instr_wr, instr_addr, instr_wdata} = instr;

  assign instr_ready = pronto_q && (state_q == S_IDLE);
  assign aceita      = instr_valid && instr_ready;
  assign idx         = addr_q[IDX_W-1:0];
  assign hit         = (rd_estado != EST_INVALIDO) && (rd_tag == addr_q);
  assign snoop       = snoop_next(rd_estado, msg_q);

`ifdef MESI_EXCLUSIVE_EN
  assign estado_fill = compartilhado_bus ? EST_COMPARTILHADO : EST_EXCLUSIVO;
`else
  assign estado_fill = EST_COMPARTILHADO;
`endif

  cache_linhas #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .IDX_W  (IDX_W)
  ) u_linhas (
    .clock     (clock),
    .reset     (reset),
    .rd_idx    (idx),
    .rd_estado (rd_estado),
    .rd_tag    (rd_tag),
    .rd_dado   (rd_dado),
    .we        (we),
    .wr_idx    (idx),
    .wr_estado (wr_estado),
    .wr_tag    (wr_tag),
    .wr_dado   (wr_dado)
  );

  // pronto_q keeps instr_ready low while reset is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pronto_q    <= 1'b0;
      dono_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      msg_q       <= MSG_SEM_MENSAGEM;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pronto_q    <= 1'b1;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      if (aceita) begin
        dono_q  <= (instr_owner == id_processador);
        wr_q    <= instr_wr;
        addr_q  <= instr_addr;
        wdata_q <= instr_wdata;
        msg_q   <= entradaMaquina;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    saida_d     = MSG_SEM_MENSAGEM;
    wb_d        = 1'b0;
    read_d      = 1'b0;
    we          = 1'b0;
    wr_estado   = rd_estado;
    wr_tag      = rd_tag;
    wr_dado     = rd_dado;
    out_d       = '0;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aceita) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_d = S_IDLE;
        if (dono_q && !wr_q) begin
          if (hit) begin
            out_d       = rd_dado;
            out_valid_d = 1'b1;
          end else begin
            saida_d = MSG_READ_MISS;
            state_d = (rd_estado == EST_MODIFICADO) ? S_WRBACK : S_FILL;
          end
        end else if (dono_q) begin
          if (hit) begin
            we        = 1'b1;
            wr_dado   = wdata_q;
            wr_estado = EST_MODIFICADO;
            if (rd_estado == EST_COMPARTILHADO) saida_d = MSG_INVALIDAR;
          end else begin
            saida_d = MSG_WRITE_MISS;
            if (rd_estado == EST_MODIFICADO) begin
              state_d = S_WRBACK;
            end else begin
              we        = 1'b1;
              wr_tag    = addr_q;
              wr_dado   = wdata_q;
              wr_estado = EST_MODIFICADO;
            end
          end
        end else if (hit) begin
          // Snooped write-back is issued here; the victim is the matching line itself.
          we        = 1'b1;
          wr_estado = snoop.proximo;
          wb_d      = snoop.wb;
        end
      end
      S_WRBACK: begin
        wb_d = 1'b1;
        if (wr_q) begin
          we        = 1'b1;
          wr_tag    = addr_q;
          wr_dado   = wdata_q;
          wr_estado = EST_MODIFICADO;
          state_d   = S_IDLE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        read_d = 1'b1;
        if (mem_ack) begin
          we          = 1'b1;
          wr_tag      = addr_q;
          wr_dado     = dadoMem;
          wr_estado   = estado_fill;
          out_d       = dadoMem;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign saidaMaquina = saida_d;
  assign WB           = wb_d;
  assign enderecoWB   = wb_d ? rd_tag : '0;
  assign dadoWB       = wb_d ? rd_dado : '0;
  assign read         = read_d;
  assign enderecoMem  = read_d ? addr_q : '0;
  assign out          = out_q;
  assign out_valid    = out_valid_q;

endmodule

// File: doc/processador_snoop_param.md
PROCESSADOR_SNOOP_PARAM -- requirements
Module: processador_snoop_param

Interface
REQ-001 SHALL have parameter PROC_ID_W, default 2, processor-id width.
REQ-002 SHALL have parameter ADDR_W, default 3, block-address width.
REQ-003 SHALL have parameter DATA_W, default 3, block-data width.
REQ-004 SHALL have parameter LINES, default 4, direct-mapped line count, power of two, at least 2 and at most 2**ADDR_W.
REQ-005 SHALL have ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- id_processador  in  PROC_ID_W  node id.
- instr_valid  in  1  instr offered.
- instr  in  PROC_ID_W+1+ADDR_W+DATA_W  {owner, wr, addr, wdata}, MSB first.
- instr_ready  out  1  instr accepted this cycle.
- entradaMaquina  in  2  bus message from owner.
- saidaMaquina  out  2  bus message driven as owner.
- WB  out  1  write-back strobe, 1 cycle.
- enderecoWB, dadoWB  out  ADDR_W, DATA_W  write-back address and data.
- read  out  1  memory read request, level.
- enderecoMem  out  ADDR_W  read address.
- dadoMem  in  DATA_W  read data.
- mem_ack  in  1  dadoMem valid.
- out  out  DATA_W  read result.
- out_valid  out  1  out valid, 1 cycle.

Function
REQ-006 SHALL decode messages as 00 invalidar, 01 readMiss, 10 writeMiss, 11 semMensagem, and line states as 00 invalido, 01 modificado, 10 compartilhado, 11 exclusivo.
REQ-007 SHALL compute line index = addr[log2(LINES)-1:0] and store the full addr as tag; hit = tag equal and state not invalido.
REQ-008 SHALL run FSM IDLE -> LOOKUP -> (WRBACK) -> (FILL) -> IDLE. instr_ready is high only in IDLE, and an instr is accepted on instr_valid&&instr_ready.
REQ-009 Owner read hit SHALL give out=line data with out_valid 2 cycles after accept, saidaMaquina=11, and no state change.
REQ-010 Owner read miss SHALL drive saidaMaquina=01 for 1 cycle in LOOKUP. A modificado victim SHALL take WRBACK first: WB=1 for 1 cycle, with victim tag/data. FILL then raises read with enderecoMem=addr until mem_ack. On mem_ack the line SHALL load {tag, dadoMem, compartilhado}, out=dadoMem, and out_valid pulses on the next cycle.
REQ-011 Owner write hit SHALL write wdata. modificado stays modificado with no message. compartilhado drives 01? no: compartilhado drives saidaMaquina=00 and becomes modificado.
REQ-012 Owner write miss SHALL drive 10, write back a modificado victim, then install {tag, wdata, modificado} without a memory read.
REQ-013 Non-owner accepted instr (owner!=id_processador) SHALL snoop entradaMaquina on the accept cycle; on tag hit, the state change commits 1 cycle later.
- readMiss: modificado -> WB then compartilhado; compartilhado unchanged.
- writeMiss: modificado -> WB then invalido; compartilhado -> invalido.
- invalidar: compartilhado -> invalido.
- semMensagem, or a tag miss: no change.
REQ-014 WB SHALL never assert on the same cycle as read. mem_ack while read is low SHALL be ignored.
REQ-015 saidaMaquina SHALL be 11 whenever no message is being driven.

Reset
REQ-016 reset SHALL asynchronously set every line to {invalido, tag 0, data 0}, FSM=IDLE, saidaMaquina=11, and all other outputs to 0.
REQ-017 reset during FILL SHALL abort the request; the line stays invalido and read deasserts immediately.

Configuration
REQ-018 With MESI_EXCLUSIVE_EN defined, an input compartilhado_bus (1 bit) SHALL exist.
- Read fill installs exclusivo when compartilhado_bus=0 at mem_ack, otherwise compartilhado.
- Write hit on exclusivo goes to modificado silently.
- Snooped readMiss on exclusivo goes to compartilhado without WB; writeMiss/invalidar on exclusivo goes to invalido.
REQ-019 Without MESI_EXCLUSIVE_EN, the port and state 11 SHALL be absent and behaviour SHALL be MSI only.

Structure
REQ-020 Package processador_snoop_pkg SHALL hold the message codes, line-state codes, FSM state enum, and the snoop next-state/write-back function.
REQ-021 Sub-module cache_linhas SHALL hold the LINES-entry state/tag/data arrays, with 1 read port and 1 write port and async reset.

Verification
REQ-022 Bench SHALL cover: id 0, line 2 modificado tag 010; read addr 110 -> saidaMaquina=01, WB with enderecoWB=010, read enderecoMem=110, mem_ack dadoMem=5 -> out=5, line compartilhado.
REQ-023 Bench SHALL cover: line 1 compartilhado tag 001; write 001 data 7 -> saidaMaquina=00, line modificado data 7, no WB.
REQ-024 Bench SHALL cover: non-owner, line 3 modificado tag 011, entradaMaquina=01, addr 011 -> WB enderecoWB=011, line compartilhado.
REQ-025 Bench SHALL cover: non-owner, tag miss, entradaMaquina=10 -> no WB, cache unchanged.
REQ-026 Bench SHALL cover: reset mid-FILL -> read=0 that cycle; after release, re-read of the same addr misses.
REQ-027 Bench SHALL cover, with MESI_EXCLUSIVE_EN: read miss with compartilhado_bus=0 -> exclusivo; a following write -> modificado with saidaMaquina=11.
